// File: rtl/apb_mat_acc.sv
// apb_mat_acc -- APB responder computing C = A x B over 2x2 unsigned 8-bit
// matrices with a single sequential multiply-accumulate engine.
//
// Ports:
//   clk, rst_n        block clock, asynchronous active-low reset
//   PADDR             APB byte address (offset = PADDR[7:0])
//   PSEL/PENABLE/
//   PWRITE/PWDATA     APB request
//   PRDATA            read data, combinational in the access phase
//   PREADY            tied 1 (zero wait states)
//   PSLVERR           error response, valid in the access phase
//   irq_o             completion interrupt (only with MAT_ACC_IRQ_EN)
//
// Register map: 0x00 CTRL (bit0 start pulse, bit1 irq_en), 0x04 STATUS
// (bit0 busy, bit1 done W1C), 0x10 A, 0x14 B, 0x20..0x2C C00..C11 (RO).
// Build option: define MAT_ACC_IRQ_EN to add irq_o and the irq_en bit.
module apb_mat_acc #(
  parameter int unsigned APB_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [31:0]               PWDATA,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR
`ifdef MAT_ACC_IRQ_EN
  ,
  output logic                      irq_o
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] a_q, b_q;
  logic [16:0] c_q [4];
  logic        done_q, done_d;
  logic        busy, mac_en, clr_c, set_done;

  // Only the low byte selects a register; upper address bits are ignored.
  logic [7:0] off;
  assign off = PADDR[7:0];

  if (APB_ADDR_WIDTH > 8) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^PADDR[APB_ADDR_WIDTH-1:8];
  end

  logic sel_ctrl, sel_stat, sel_a, sel_b, sel_c, mapped;
  logic access, err, wr_en, start_req;

  always_comb begin
    sel_ctrl = (off == 8'h00);
    sel_stat = (off == 8'h04);
    sel_a    = (off == 8'h10);
    sel_b    = (off == 8'h14);
    sel_c    = (off == 8'h20) || (off == 8'h24) || (off == 8'h28) || (off == 8'h2C);
    mapped   = sel_ctrl | sel_stat | sel_a | sel_b | sel_c;
  end

  assign access    = PSEL & PENABLE;
  assign err       = access & (~mapped | (PWRITE & sel_c) | (PWRITE & busy & (sel_a | sel_b)));
  assign wr_en     = access & PWRITE & ~err;
  assign start_req = wr_en & sel_ctrl & PWDATA[0];

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state. cnt_q walks the 8 MAC steps: [2]=row, [1]=col, [0]=term.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start_req) begin
        state_d = CALC;
        cnt_d   = '0;
      end
      CALC: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (state_q == CALC);
    mac_en   = (state_q == CALC);
    clr_c    = (state_q == IDLE) & start_req;
    set_done = (state_q == CALC) & (cnt_q == 3'd7);
  end

  // Element (r,k) of A times element (k,c) of B for the current step.
  logic [7:0]  a_el, b_el;
  logic [15:0] prod;
  assign a_el = a_q[8*{cnt_q[2], cnt_q[0]} +: 8];
  assign b_el = b_q[8*{cnt_q[0], cnt_q[1]} +: 8];
  assign prod = {8'b0, a_el} * {8'b0, b_el};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      for (int unsigned i = 0; i < 4; i++) c_q[i] <= '0;
    end else begin
      if (wr_en & sel_a) a_q <= PWDATA;
      if (wr_en & sel_b) b_q <= PWDATA;
      if (clr_c) begin
        for (int unsigned i = 0; i < 4; i++) c_q[i] <= '0;
      end else if (mac_en) begin
        c_q[cnt_q[2:1]] <= c_q[cnt_q[2:1]] + {1'b0, prod};
      end
    end
  end

  // Completion set takes priority over a coincident W1C.
  always_comb begin
    done_d = done_q;
    if (wr_en & sel_stat & PWDATA[1]) done_d = 1'b0;
    if (set_done)                     done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= done_d;
  end

`ifdef MAT_ACC_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q;
  assign irq_en_d = (wr_en & sel_ctrl) ? PWDATA[1] : irq_en_q;

  // Registered from next-state values so irq_o tracks done & irq_en exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= done_d & irq_en_d;
    end
  end
  assign irq_o = irq_q;
`endif

  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    case (off)
`ifdef MAT_ACC_IRQ_EN
      8'h00: rdata[1] = irq_en_q;
`endif
      8'h04: rdata = {30'b0, done_q, busy};
      8'h10: rdata = a_q;
      8'h14: rdata = b_q;
      8'h20: rdata = {15'b0, c_q[0]};
      8'h24: rdata = {15'b0, c_q[1]};
      8'h28: rdata = {15'b0, c_q[2]};
      8'h2C: rdata = {15'b0, c_q[3]};
      default: rdata = '0;
    endcase
  end

  assign PRDATA  = (PSEL & ~PWRITE) ? rdata : '0;
  assign PREADY  = 1'b1;
  assign PSLVERR = err;

endmodule

// File: tb/tb_apb_mat_acc.sv
// Testbench for apb_mat_acc: randomized and directed APB traffic checked
// against a matrix-arithmetic reference model indexed by cycles since start.
module tb_apb_mat_acc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
`ifdef MAT_ACC_IRQ_EN
  logic        irq_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_mat_acc #(.APB_ADDR_WIDTH(12)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .PADDR  (PADDR),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
`ifdef MAT_ACC_IRQ_EN
    ,
    .irq_o  (irq_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: element (r,c) of a row-major packed 2x2 byte matrix.
  function automatic int elem(input logic [31:0] m, input int r, input int c);
    return int'(m[8*(2*r+c) +: 8]);
  endfunction

  // C register n after 'macs' MAC steps in order C00,C01,C10,C11, two terms each.
  function automatic logic [31:0] c_model(input logic [31:0] a, input logic [31:0] b,
                                         input int n, input int macs);
    int s;
    s = 0;
    for (int t = 0; t < macs; t++)
      if (t / 2 == n) s += elem(a, n / 2, t % 2) * elem(b, t % 2, n % 2);
    return s;
  endfunction

  // STATUS for cycle k after a start (k=1 is the cycle after the start edge).
  function automatic logic [31:0] stat_model(input int k);
    return {30'b0, 1'b0, 1'b0} | ((k >= 9) ? 32'h2 : 32'h0) | ((k >= 1 && k <= 8) ? 32'h1 : 32'h0);
  endfunction

  // All tasks are entered 1ns after a rising edge and return 1ns after one.
  task automatic apb_write(input logic [7:0] off, input logic [31:0] d, output logic e);
    PADDR = {4'h0, off}; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1 PENABLE = 1'b1;
    #1 e = PSLVERR;
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] off, output logic [31:0] d, output logic e,
                          output int k);
    PADDR = {4'h0, off}; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1 PENABLE = 1'b1;
    #1 d = PRDATA; e = PSLVERR; k = cyc - t0 + 1;
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] d; logic e; int k;
    apb_read(off, d, e, k);
    check({tag, "_data"}, d, exp);
    check({tag, "_err"}, {31'b0, e}, 32'h0);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic irqen);
    logic e;
    apb_write(8'h10, a, e);    check("wr_a_err", {31'b0, e}, 32'h0);
    apb_write(8'h14, b, e);    check("wr_b_err", {31'b0, e}, 32'h0);
    apb_write(8'h04, 32'h2, e);
    apb_write(8'h00, {30'b0, irqen, 1'b1}, e);
    check("start_err", {31'b0, e}, 32'h0);
    t0 = cyc;
  endtask

  // Start an operation and sample random registers while it runs.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic irqen,
                       input int skew);
    logic [7:0]  offs [5];
    logic [7:0]  off;
    logic [31:0] d, exp;
    logic        e;
    int          k, macs;
    offs = '{8'h04, 8'h20, 8'h24, 8'h28, 8'h2C};
    start_op(a, b, irqen);
    if (skew != 0) idle(1);
    for (int it = 0; it < 8; it++) begin
      off = offs[$urandom_range(0, 4)];
      apb_read(off, d, e, k);
      macs = (k - 1 > 8) ? 8 : k - 1;
      exp  = (off == 8'h04) ? stat_model(k) : c_model(a, b, (int'(off) - 'h20) / 4, macs);
      check($sformatf("run_k%0d_off%02h", k, off), d, exp);
      check("run_rd_err", {31'b0, e}, 32'h0);
`ifdef MAT_ACC_IRQ_EN
      check($sformatf("run_irq_k%0d", k), {31'b0, irq_o}, {31'b0, irqen && k >= 9});
`endif
      if (k >= 10) break;
    end
    for (int n = 0; n < 4; n++)
      read_chk($sformatf("final_c%0d", n), 8'(8'h20 + 4 * n), c_model(a, b, n, 8));
    read_chk("final_status", 8'h04, 32'h2);
  endtask

  logic [31:0] d;
  logic        e;
  int          k;
  logic [31:0] exp29 [4];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    #1;
    check("rst_pready", {31'b0, PREADY}, 32'h1);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
`ifdef MAT_ACC_IRQ_EN
    check("rst_irq", {31'b0, irq_o}, 32'h0);
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    read_chk("rst_ctrl", 8'h00, 32'h0);
    read_chk("rst_status", 8'h04, 32'h0);
    read_chk("rst_a", 8'h10, 32'h0);
    read_chk("rst_c11", 8'h2C, 32'h0);

    // Reference vector with known results.
    exp29 = '{32'd19, 32'd22, 32'd43, 32'd50};
    do_op(32'h04030201, 32'h08070605, 1'b0, 0);
    for (int n = 0; n < 4; n++)
      read_chk($sformatf("ref_c%0d", n), 8'(8'h20 + 4 * n), exp29[n]);

    // Maximum operands: no truncation of the 17-bit sums.
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1);
    for (int n = 0; n < 4; n++)
      read_chk($sformatf("max_c%0d", n), 8'(8'h20 + 4 * n), 32'h0001FC02);

    // Randomized operands, interrupt enable and sampling phase.
    for (int r = 0; r < 10; r++)
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), r % 2);

    // Busy-time writes: A discarded with error, restart ignored silently.
    start_op(32'h01020304, 32'h05060708, 1'b0);
    apb_write(8'h10, 32'h11111111, e);  check("busy_wr_a_err", {31'b0, e}, 32'h1);
    apb_write(8'h00, 32'h1, e);         check("busy_start_err", {31'b0, e}, 32'h0);
    read_chk("busy_rd_a", 8'h10, 32'h01020304);
    apb_read(8'h04, d, e, k); check($sformatf("busy_stat_k%0d", k), d, stat_model(k));
    apb_read(8'h04, d, e, k); check($sformatf("busy_stat_k%0d", k), d, stat_model(k));
    idle(10);
    read_chk("busy_no_rerun", 8'h04, 32'h2);
    for (int n = 0; n < 4; n++)
      read_chk($sformatf("busy_c%0d", n), 8'(8'h20 + 4 * n),
               c_model(32'h01020304, 32'h05060708, n, 8));

    // Unmapped read, RO write, CTRL write without start.
    apb_read(8'h40, d, e, k);
    check("unmapped_err", {31'b0, e}, 32'h1);
    check("unmapped_data", d, 32'h0);
    apb_write(8'h20, 32'hDEADBEEF, e);  check("ro_wr_err", {31'b0, e}, 32'h1);
    read_chk("ro_c00_kept", 8'h20, c_model(32'h01020304, 32'h05060708, 0, 8));
    apb_write(8'h04, 32'h2, e);
    apb_write(8'h00, 32'h2, e);         check("ctrl_nostart_err", {31'b0, e}, 32'h0);
    idle(3);
    read_chk("ctrl_nostart_stat", 8'h04, 32'h0);
`ifdef MAT_ACC_IRQ_EN
    read_chk("ctrl_irqen_rd", 8'h00, 32'h2);
`else
    read_chk("ctrl_irqen_rd", 8'h00, 32'h0);
`endif

    // W1C landing on the completion edge: set wins.
    start_op(32'h0A0B0C0D, 32'h01010101, 1'b0);
    for (int g = 0; g < 20; g++) begin
      if (cyc - t0 + 1 >= 7) break;
      idle(1);
    end
    apb_write(8'h04, 32'h2, e);
    read_chk("w1c_collide", 8'h04, 32'h2);
    apb_write(8'h04, 32'h2, e);
    read_chk("w1c_clear", 8'h04, 32'h0);

`ifdef MAT_ACC_IRQ_EN
    do_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 0);
    check("irq_set", {31'b0, irq_o}, 32'h1);
    apb_write(8'h04, 32'h2, e);
    check("irq_clr", {31'b0, irq_o}, 32'h0);
`endif

    // Reset in the middle of a calculation.
    start_op(32'hFFEEDDCC, 32'h11223344, 1'b1);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    read_chk("mid_rst_status", 8'h04, 32'h0);
    read_chk("mid_rst_c00", 8'h20, 32'h0);
    #1 rst_n = 1'b1;
    read_chk("post_rst_a", 8'h10, 32'h0);
    read_chk("post_rst_b", 8'h14, 32'h0);
    read_chk("post_rst_ctrl", 8'h00, 32'h0);
    idle(15);
    read_chk("post_rst_no_done", 8'h04, 32'h0);
`ifdef MAT_ACC_IRQ_EN
    check("post_rst_irq", {31'b0, irq_o}, 32'h0);
`endif
    apb_write(8'h10, 32'hCAFEF00D, e);
    read_chk("post_rst_first_wr", 8'h10, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_mat_acc.md
APB_MAT_ACC -- requirements
Module: apb_mat_acc

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 12, APB address bits decoded.
REQ-002 clk  in  1  block clock; one clock only.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 PADDR  in  APB_ADDR_WIDTH  APB byte address.
REQ-005 PSEL, PENABLE, PWRITE  in  1 each  APB request controls.
REQ-006 PWDATA  in  32  APB write data.
REQ-007 PRDATA  out  32  APB read data.
REQ-008 PREADY  out  1  APB ready, tied 1 (zero wait states).
REQ-009 PSLVERR  out  1  APB error, valid in the access phase.
REQ-010 irq_o  out  1  completion interrupt, present only with MAT_ACC_IRQ_EN.

Function
REQ-011 Block SHALL be an APB responder computing C = A x B over 2x2 unsigned 8-bit matrices with a sequential MAC engine.
REQ-012 Register map (offset = PADDR[7:0]) SHALL be: 0x00 CTRL (W, bit0 start, write-1 pulse; bit1 irq_en, R/W); 0x04 STATUS (bit0 busy RO, bit1 done W1C); 0x10 A; 0x14 B; 0x20/0x24/0x28/0x2C C00/C01/C10/C11 (RO).
REQ-013 A and B SHALL pack elements as [7:0]=x00, [15:8]=x01, [23:16]=x10, [31:24]=x11.
REQ-014 Each C register SHALL hold the 17-bit unsigned sum of two 16-bit products, zero-extended to 32 bits; no overflow possible.
REQ-015 Writes SHALL take effect on the clock edge where PSEL&PENABLE&PWRITE; reads SHALL return PRDATA combinationally in that access phase.
REQ-016 FSM states: IDLE, CALC, DONE; IDLE->CALC on start write; CALC runs exactly 8 cycles (one product-accumulate per cycle, order C00,C01,C10,C11, two terms each); CALC->DONE after cycle 8; DONE->IDLE after one cycle.
REQ-017 Start accepted at edge T SHALL give busy=1 from T+1 through T+8, all four C updated and done=1, busy=0 visible from T+9.
REQ-018 C registers SHALL be cleared at the start of CALC and SHALL read as partial results while busy.
REQ-019 Start write while busy SHALL be ignored, PSLVERR=0.
REQ-020 Writes to A or B while busy SHALL be discarded with PSLVERR=1; reads while busy SHALL be error-free.
REQ-021 Access to an unmapped offset or write to a RO register SHALL give PSLVERR=1, PRDATA=0, no state change.
REQ-022 done SHALL remain set until written 1 to STATUS bit1; completion coincident with a W1C SHALL leave done=1 (set wins).
REQ-023 Start write with bit0=0 SHALL only update irq_en.

Reset
REQ-024 rst_n low SHALL asynchronously force FSM=IDLE, A, B, all C, irq_en, busy, done, PRDATA to 0, PSLVERR 0, PREADY 1, irq_o 0.
REQ-025 Reset mid-CALC SHALL abort the computation; no done and no irq after release.
REQ-026 Reset deassertion SHALL be consumed synchronously to clk; first access accepted on the first edge after release.

Configuration
REQ-027 With macro MAT_ACC_IRQ_EN defined, irq_o SHALL exist and equal done & irq_en as a registered level.
REQ-028 Without MAT_ACC_IRQ_EN, irq_o port SHALL be absent, CTRL bit1 SHALL read 0 and ignore writes; all other behaviour identical.

Verification
REQ-029 A=0x04030201, B=0x08070605, start -> after 9 cycles C00=19, C01=22, C10=43, C11=50, STATUS=0x2.
REQ-030 A=B=0xFFFFFFFF, start -> every C = 0x0001FC02, no truncation.
REQ-031 Start, then at T+3 write A=0x11111111 and start again -> PSLVERR=1 on A write, A unchanged, results of first operands only, busy drops at T+9.
REQ-032 Read offset 0x40 and write 0x20 -> PSLVERR=1, PRDATA=0, C00 unchanged.
REQ-033 Assert rst_n=0 at T+4 of CALC -> all registers 0, STATUS=0, no later done.
REQ-034 With MAT_ACC_IRQ_EN, CTRL=0x3 -> irq_o=1 after completion; W1C STATUS=0x2 -> irq_o=0 next cycle.
